// File: rtl/sdram_word_bridge_if.sv
// CPU word-request / SDRAM half-word bus bundle for the word bridge.
interface sdram_word_bridge_if #(
    parameter int WADDR_W = 23
);
    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [WADDR_W-1:0] req_addr;
    logic [31:0]        req_wdata;
    logic               rsp_valid;
    logic [31:0]        rsp_rdata;
    logic               busy;
    logic               mem_we;
    logic [WADDR_W:0]   mem_addr;
    logic [15:0]        mem_wdata;
    logic [15:0]        mem_rdata;

    // Bridge view: consumes CPU requests, drives the controller side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, busy, mem_we, mem_addr, mem_wdata
    );

    // Requester / memory-model view.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, busy, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sdram_word_bridge.sv
// Splits 32-bit word requests into low-then-high 16-bit controller
// transactions and reassembles read data into a one-cycle response.
//
// state  | meaning
// IDLE   | ready for a new word request
// LO     | low half-word held on the controller for PHASE_CYCLES
// HI     | high half-word held on the controller for PHASE_CYCLES
// RESP   | one-cycle rsp_valid pulse, not ready
module sdram_word_bridge #(
    parameter int PHASE_CYCLES = 2,
    parameter int WADDR_W      = 23
) (
    input logic                 clk,
    input logic                 reset,
    sdram_word_bridge_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [3:0] CNT_LAST = 4'(PHASE_CYCLES - 1);

    logic [1:0]         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [WADDR_W-1:0] addr_q, addr_d;
    logic [15:0]        whi_q, whi_d;
    logic               mem_we_q, mem_we_d;
    logic [WADDR_W:0]   mem_addr_q, mem_addr_d;
    logic [15:0]        mem_wdata_q, mem_wdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;

    logic phase_last;
    assign phase_last = (cnt_q == CNT_LAST);

    // Next-state and controller-bus sequencing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        whi_d       = whi_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d        = bus.req_we;
                    addr_d      = bus.req_addr;
                    whi_d       = bus.req_wdata[31:16];
                    mem_we_d    = bus.req_we;
                    mem_addr_d  = {bus.req_addr, 1'b0};
                    mem_wdata_d = bus.req_wdata[15:0];
                    cnt_d       = 4'd0;
                    state_d     = S_LO;
                end
            end
            S_LO: begin
                if (phase_last) begin
                    if (!we_q) rsp_rdata_d[15:0] = bus.mem_rdata;
                    mem_addr_d  = {addr_q, 1'b1};
                    mem_wdata_d = whi_q;
                    cnt_d       = 4'd0;
                    state_d     = S_HI;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_HI: begin
                if (phase_last) begin
                    if (!we_q) rsp_rdata_d[31:16] = bus.mem_rdata;
                    mem_we_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    cnt_d       = 4'd0;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            whi_q       <= 16'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 16'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            whi_q       <= whi_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_sdram_word_bridge.sv
// Bench for sdram_word_bridge: directed phase checks plus a response scoreboard.
module tb_sdram_word_bridge;
    localparam int P  = 2;
    localparam int AW = 23;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sdram_word_bridge_if #(.WADDR_W(AW)) bus ();

    sdram_word_bridge #(.PHASE_CYCLES(P), .WADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd = 32'd0;

    function automatic logic [15:0] mem_model(input logic [AW:0] a);
        case (a)
            24'h000020: return 16'h1234;
            24'h000021: return 16'h5678;
            default:    return a[15:0] ^ 16'h3C5A;
        endcase
    endfunction

    function automatic logic [31:0] rd_exp(input logic [AW-1:0] a);
        return {mem_model({a, 1'b1}), mem_model({a, 1'b0})};
    endfunction

    always_comb bus.mem_rdata = mem_model(bus.mem_addr);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Response scoreboard: each rsp_valid pops one expected read word.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
                else check("rsp_rdata", bus.rsp_rdata, exp_q.pop_front());
            end
        end
    end

    // Issue one request (called at a negedge); nv/nwe/naddr/nwd are driven while busy.
    task automatic run_req(input string tag, input logic we, input logic [AW-1:0] addr,
                           input logic [31:0] wd, input logic nv, input logic nwe,
                           input logic [AW-1:0] naddr, input logic [31:0] nwd);
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check({tag, "_accept_timeout"}, 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        if (!we) last_rd = rd_exp(addr);
        exp_q.push_back(last_rd);
        @(negedge clk);
        bus.req_valid = nv;
        bus.req_we    = nwe;
        bus.req_addr  = naddr;
        bus.req_wdata = nwd;
        for (int c = 1; c <= 2 * P; c++) begin
            logic [AW:0] ea;
            logic [15:0] ed;
            ea = (c <= P) ? {addr, 1'b0} : {addr, 1'b1};
            ed = (c <= P) ? wd[15:0] : wd[31:16];
            check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(ea));
            check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'(ed));
            check({tag, "_mem_we"}, 32'(bus.mem_we), 32'(we));
            check({tag, "_ready_busy"}, 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, "_resp_mem_we"}, 32'(bus.mem_we), 32'd0);
        check({tag, "_resp_ready"}, 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check({tag, "_ready_back"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_rsp_clear"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);

        run_req("wr", 1'b1, 23'h000010, 32'hDEADBEEF, 1'b0, 1'b0, 23'h7F0F0F, 32'h0BADF00D);
        run_req("rd", 1'b0, 23'h000010, 32'h00000000, 1'b0, 1'b1, 23'h000011, 32'hFFFFFFFF);

        // Second request held pending while the first is in flight.
        run_req("b2b_wr", 1'b1, 23'h000123, 32'h01020304, 1'b1, 1'b0, 23'h000055, 32'h99999999);
        run_req("b2b_rd", 1'b0, 23'h000055, 32'h99999999, 1'b0, 1'b0, 23'h000000, 32'h0);

        run_req("bnd_wr", 1'b1, 23'h7FFFFF, 32'hA5A55A5A, 1'b0, 1'b0, 23'h0, 32'h0);
        run_req("bnd_rd", 1'b0, 23'h7FFFFF, 32'h00000000, 1'b0, 1'b0, 23'h0, 32'h0);

        // Reset and request together: reset wins.
        reset         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 23'h000300;
        bus.req_wdata = 32'h12345678;
        exp_q.delete();
        last_rd = 32'd0;
        @(negedge clk);
        check("rstreq_busy", 32'(bus.busy), 32'd0);
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rstreq_busy2", 32'(bus.busy), 32'd0);
        check("rstreq_mem_we", 32'(bus.mem_we), 32'd0);

        // Reset during the high half of a write.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 23'h000040;
        bus.req_wdata = 32'h11112222;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_in_hi_addr", 32'(bus.mem_addr), 32'h00000081);
        check("midrst_in_hi_we", 32'(bus.mem_we), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_mem_we", 32'(bus.mem_we), 32'd0);
        check("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        exp_q.delete();
        last_rd = 32'd0;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_ready", 32'(bus.req_ready), 32'd1);
        repeat (6) @(negedge clk);
        run_req("post_rst_rd", 1'b0, 23'h000010, 32'h0, 1'b0, 1'b0, 23'h0, 32'h0);

        for (int i = 0; i < 6; i++) begin
            logic rwe;
            logic [AW-1:0] ra;
            logic [31:0] rwd;
            rwe = 1'($urandom_range(0, 1));
            ra  = AW'($urandom);
            rwd = $urandom;
            run_req("rand", rwe, ra, rwd, 1'b0, ~rwe, ~ra, ~rwd);
        end

        repeat (3) @(negedge clk);
        check("rsp_missing", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdram_word_bridge.md
Name: sdram_word_bridge

Overview:
- Upstream front end for the sdram_controller.
- Accepts 32-bit word read/write requests from the CPU/bus side using a valid/ready handshake.
- Splits each request into two sequenced 16-bit half-word transactions on the controller's we/addr/data_in/data_out interface, low half first, then high half.
- Reassembles read data and returns a single-cycle response pulse per request.

Parameters:
- PHASE_CYCLES, 2: cycles each half-word transaction is held on the controller interface; legal range 1..15.
- WADDR_W, 23: CPU word-address width; controller half-word address is WADDR_W+1 = 24 bits.

Ports:
- clk  in  1  system clock (also drives the controller)
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  bridge can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  WADDR_W  word address
- req_wdata  in  32  write data
- rsp_valid  out  1  one-cycle pulse: request complete (read or write)
- rsp_rdata  out  32  read data, valid when rsp_valid is high for a read
- busy  out  1  high whenever state is not IDLE
- mem_we  out  1  to controller we
- mem_addr  out  WADDR_W+1  to controller addr
- mem_wdata  out  16  to controller data_in
- mem_rdata  in  16  from controller data_out

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on reset. All outputs are registered except req_ready and busy, which decode from state.
- Reset values: state=IDLE; mem_we=0; mem_addr=0; mem_wdata=0; rsp_valid=0; rsp_rdata=0; phase counter=0. After reset, req_ready=1 and busy=0.
- States: IDLE, LO, HI, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at edge T: latch we, addr, wdata; drive mem_addr={req_addr,1'b0}, mem_wdata=req_wdata[15:0], mem_we=req_we; go to LO.
- LO:
  - Active for cycles T+1..T+PHASE_CYCLES; counter runs 0..PHASE_CYCLES-1.
  - On the edge where counter==PHASE_CYCLES-1:
    - For reads, capture mem_rdata into rsp_rdata[15:0].
    - Drive mem_addr={addr,1'b1}, mem_wdata=wdata[31:16]; mem_we holds the latched we.
    - Reset counter; go to HI.
- HI:
  - Active for cycles T+PHASE_CYCLES+1..T+2*PHASE_CYCLES.
  - On the last edge:
    - For reads, capture mem_rdata into rsp_rdata[31:16].
    - Set mem_we=0 and rsp_valid=1; go to RESP.
- RESP:
  - Lasts exactly one cycle (T+2*PHASE_CYCLES+1); rsp_valid=1, req_ready=0.
  - Next edge: rsp_valid=0; go to IDLE.
  - req_ready returns high at T+2*PHASE_CYCLES+2.
- Latency and throughput: request to rsp_valid is 2*PHASE_CYCLES+1 cycles. Maximum throughput is one request per 2*PHASE_CYCLES+2 cycles.
- mem_we is high only during LO/HI of a write. It never glitches between LO and HI, and is low in IDLE and RESP.
- rsp_rdata is updated only by reads. Writes leave it unchanged.
- Request inputs are sampled only at acceptance; changes while busy are ignored.
- req_valid held high while req_ready=0 is not consumed. It is accepted on the first IDLE cycle.
- Address boundary: req_addr all-ones maps to half-word addresses 0xFFFFFE then 0xFFFFFF (WADDR_W=23). No wrap or carry into other bits.
- Reset mid-operation (LO/HI/RESP): the next edge forces the reset values. mem_we drops at that edge, no rsp_valid is issued for the aborted request, and req_ready is high the following cycle.
- reset and req_valid high together: reset wins; no request is accepted.

Test Plan (PHASE_CYCLES=2):
- Write: req_we=1, addr=0x000010, wdata=0xDEADBEEF accepted at cycle 0 ->
  - cycles 1-2: mem_addr=0x000020, mem_wdata=0xBEEF, mem_we=1
  - cycles 3-4: mem_addr=0x000021, mem_wdata=0xDEAD, mem_we=1
  - cycle 5: rsp_valid=1, mem_we=0
  - cycle 6: req_ready=1
- Read: model drives mem_rdata=0x1234 for 0x000020 and 0x5678 for 0x000021; read addr=0x000010 -> mem_we=0 throughout; cycle 5: rsp_valid=1, rsp_rdata=0x56781234.
- Back-to-back: req_valid held high with two queued requests -> second accepted at cycle 6 (first IDLE cycle); exactly one rsp_valid per request; input changes during busy have no effect.
- Boundary address: write addr=0x7FFFFF, wdata=0xA5A55A5A -> mem_addr 0xFFFFFE with 0x5A5A, then 0xFFFFFF with 0xA5A5.
- Reset mid-write: assert reset during cycle 3 (HI) -> mem_we=0 and mem_addr=0 after that edge; no rsp_valid; req_ready=1 the cycle after reset deasserts; a following read completes normally.
